// File: rtl/tick_period_meter.sv
// -----------------------------------------------------------------------------
// tick_period_meter
//
// Measures a slow, possibly asynchronous square wave (typically a clock-divider
// tick such as the 1 Hz toggle) in system-clock cycles. The input is
// synchronised, optionally glitch-filtered, and edge-detected. A two-state FSM
// counts cycles between rising edges and captures the high time. It flags loss
// of signal when no rising edge arrives within TIMEOUT cycles.
//
// Optional feature macro: TICK_GLITCH_FILT_EN
//   When defined, a stability filter of FILT_LEN cycles sits between the
//   synchroniser and the edge register. Pulses shorter than FILT_LEN cycles are
//   discarded. Detection latency grows by FILT_LEN cycles.
//
// Ports:
//   clk          system clock (50 MHz nominal)
//   rst_n        asynchronous active-low reset
//   sig_in       square wave to measure, asynchronous to clk
//   period       clk cycles between the last two detected rising edges
//   high_time    clk cycles from a rise to the following fall in that period
//   period_valid one-cycle pulse when period/high_time update
//   locked       1 while a measurement is running (MEAS state)
//   timeout      sticky loss-of-signal flag, cleared by the next rise
// -----------------------------------------------------------------------------
module tick_period_meter #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 50_000_000,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Elaboration-time parameter sanity checks.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("tick_period_meter: SYNC_STAGES must be >= 2");
    end
    if (FILT_LEN < 1) begin : g_bad_filt
        $error("tick_period_meter: FILT_LEN must be >= 1");
    end
    if (TIMEOUT < 1 || (CNT_W < 63 && longint'(TIMEOUT) >= (longint'(1) << CNT_W))) begin : g_bad_to
        $error("tick_period_meter: TIMEOUT must be in 1 .. 2**CNT_W-1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   s;
    logic                   lvl;
    logic                   s_d;
    logic                   rise;
    logic                   fall;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [CNT_W-1:0]       hcap;
    logic [CNT_W-1:0]       hcap_nxt;
    logic [CNT_W-1:0]       period_nxt;
    logic [CNT_W-1:0]       high_nxt;
    logic                   valid_nxt;
    logic                   timeout_nxt;

    // Synchroniser stage: sig_in enters at bit 0, s leaves the last flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], sig_in};
        end
    end

    assign s = sync_chain[SYNC_STAGES-1];

`ifdef TICK_GLITCH_FILT_EN
    // Filter stage: the level follows s only after s has differed from it for
    // FILT_LEN consecutive cycles; any agreement restarts the run.
    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [FW-1:0] filt_cnt;
    logic          filt_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= '0;
            filt_lvl <= 1'b0;
        end else if (s == filt_lvl) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
            filt_lvl <= s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign lvl = filt_lvl;
`else
    assign lvl = s;
`endif

    // Edge register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_d <= 1'b0;
        end else begin
            s_d <= lvl;
        end
    end

    // Rise and fall are mutually exclusive because both derive from one level.
    assign rise = lvl & ~s_d;
    assign fall = ~lvl & s_d;

    // Measurement FSM stage: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            hcap         <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            hcap         <= hcap_nxt;
            period       <= period_nxt;
            high_time    <= high_nxt;
            period_valid <= valid_nxt;
            timeout      <= timeout_nxt;
        end
    end

    // Next-state logic. cnt counts cycles since the last rise, starting at 1 on
    // the rise cycle, so the value seen on the next rise is the full period.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hcap_nxt    = hcap;
        period_nxt  = period;
        high_nxt    = high_time;
        valid_nxt   = 1'b0;
        timeout_nxt = timeout;
        case (state)
            IDLE: begin
                if (rise) begin
                    // First rise only arms the measurement.
                    state_nxt   = MEAS;
                    cnt_nxt     = CNT_ONE;
                    timeout_nxt = 1'b0;
                end else begin
                    cnt_nxt = '0;
                end
            end
            MEAS: begin
                if (rise) begin
                    // A rise on the TIMEOUT cycle still wins over loss of signal.
                    period_nxt = cnt;
                    high_nxt   = hcap;
                    valid_nxt  = 1'b1;
                    cnt_nxt    = CNT_ONE;
                end else if (cnt == TIMEOUT_CNT) begin
                    // Loss of signal; last measurement is kept for display.
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                    cnt_nxt     = '0;
                end else begin
                    if (fall) begin
                        hcap_nxt = cnt;
                    end
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign locked = (state == MEAS);

endmodule
